// File: rtl/mod_addsub_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : mod_addsub_ctrl
// Description : Sequencer for modular add/subtract on a shared multi-precision
//               add/sub datapath. Each request issues a raw op (a+b or a-b)
//               followed by a correction op (r-M or r+M), then selects the
//               reduced result. Both ops are always issued, so the run time
//               depends only on datapath latency and never on operand values.
//
// Ports       : clk, reset       - clock (rising edge), async active-high reset
//               start, op_sub    - request pulse (accepted in IDLE), 0=add 1=sub
//               in_a, in_b, in_m - operands a, b (< M) and modulus M (> 0)
//               busy, done       - operation in flight / one-cycle completion
//               result           - reduced result, held until next completion
//               add_start        - one-cycle start pulse to datapath
//               add_subtract     - datapath mode, 0=add 1=subtract
//               add_in_a/b       - datapath operands (WIDTH+1 bits)
//               add_result       - datapath result (WIDTH+2 bits, two's compl.)
//               add_done         - datapath completion level
//
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module mod_addsub_ctrl #(
    parameter int WIDTH = 512
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_m,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             add_start,
    output logic             add_subtract,
    output logic [WIDTH:0]   add_in_a,
    output logic [WIDTH:0]   add_in_b,
    input  logic [WIDTH+1:0] add_result,
    input  logic             add_done
);

    //--------------------------------------------------------------------------
    // State encoding
    //--------------------------------------------------------------------------
    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_issue1 = 3'd1;
    localparam logic [2:0] c_st_wait1  = 3'd2;
    localparam logic [2:0] c_st_issue2 = 3'd3;
    localparam logic [2:0] c_st_wait2  = 3'd4;
    localparam logic [2:0] c_st_select = 3'd5;
    localparam logic [2:0] c_st_done   = 3'd6;

    //--------------------------------------------------------------------------
    // Registers
    //--------------------------------------------------------------------------
    logic [2:0]       r_state;
    logic             r_op_sub;     // captured operation
    logic [WIDTH-1:0] r_m;          // captured modulus
    logic             r_armed;      // set after the first WAIT cycle
    logic             r_r_neg;      // sign of raw result r
    logic [WIDTH-1:0] r_r_low;      // low WIDTH bits of raw result r
    logic             r_t_neg;      // sign of corrected result t
    logic [WIDTH-1:0] r_t_low;      // low WIDTH bits of corrected result t

    logic [WIDTH-1:0] w_result_sel;

    //--------------------------------------------------------------------------
    // Result selection.
    //   add: t = r - M. If t went negative then r < M and r is already reduced.
    //   sub: r = a - b. If r is negative the wrapped value r + M is the answer.
    //--------------------------------------------------------------------------
    always_comb begin
        w_result_sel = r_r_low;
        if (r_op_sub) begin
            w_result_sel = r_r_neg ? r_t_low : r_r_low;
        end else begin
            w_result_sel = r_t_neg ? r_r_low : r_t_low;
        end
    end

    //--------------------------------------------------------------------------
    // Sequencer. All datapath-facing outputs are registered and loaded on the
    // transition into ISSUEx, so they are valid during ISSUEx and stay constant
    // through the following WAITx.
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= c_st_idle;
            r_op_sub     <= 1'b0;
            r_m          <= '0;
            r_armed      <= 1'b0;
            r_r_neg      <= 1'b0;
            r_r_low      <= '0;
            r_t_neg      <= 1'b0;
            r_t_low      <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            result       <= '0;
            add_start    <= 1'b0;
            add_subtract <= 1'b0;
            add_in_a     <= '0;
            add_in_b     <= '0;
        end else begin
            // Pulses default low every cycle.
            add_start <= 1'b0;
            done      <= 1'b0;

            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_op_sub     <= op_sub;
                        r_m          <= in_m;
                        add_in_a     <= {1'b0, in_a};
                        add_in_b     <= {1'b0, in_b};
                        add_subtract <= op_sub;
                        add_start    <= 1'b1;
                        busy         <= 1'b1;
                        r_state      <= c_st_issue1;
                    end
                end

                c_st_issue1: begin
                    r_armed <= 1'b0;
                    r_state <= c_st_wait1;
                end

                c_st_wait1: begin
                    // The first WAIT cycle may still see add_done left high by
                    // the previous operation, so it is never trusted.
                    if (!r_armed) begin
                        r_armed <= 1'b1;
                    end else if (add_done) begin
                        r_r_neg      <= add_result[WIDTH+1];
                        r_r_low      <= add_result[WIDTH-1:0];
                        // Correction: add -> r - M, sub -> r + M.
                        add_in_a     <= add_result[WIDTH:0];
                        add_in_b     <= {1'b0, r_m};
                        add_subtract <= ~r_op_sub;
                        add_start    <= 1'b1;
                        r_state      <= c_st_issue2;
                    end
                end

                c_st_issue2: begin
                    r_armed <= 1'b0;
                    r_state <= c_st_wait2;
                end

                c_st_wait2: begin
                    if (!r_armed) begin
                        r_armed <= 1'b1;
                    end else if (add_done) begin
                        r_t_neg <= add_result[WIDTH+1];
                        r_t_low <= add_result[WIDTH-1:0];
                        r_state <= c_st_select;
                    end
                end

                c_st_select: begin
                    result  <= w_result_sel;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    r_state <= c_st_done;
                end

                c_st_done: begin
                    // start is ignored here; a new request is taken in IDLE.
                    r_state <= c_st_idle;
                end

                default: begin
                    busy    <= 1'b0;
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mod_addsub_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_mod_addsub_ctrl
// Description : Self-checking bench for mod_addsub_ctrl. Contains a datapath
//               model with configurable latency and an optional "sticky done"
//               mode, plus a reference model of the modular result and the
//               expected cycle-level timing of all outputs.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_mod_addsub_ctrl;

    localparam int W = 512;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic           op_sub;
    logic [W-1:0]   in_a;
    logic [W-1:0]   in_b;
    logic [W-1:0]   in_m;
    logic           busy;
    logic           done;
    logic [W-1:0]   result;
    logic           add_start;
    logic           add_subtract;
    logic [W:0]     add_in_a;
    logic [W:0]     add_in_b;
    logic [W+1:0]   add_result;
    logic           add_done;

    mod_addsub_ctrl #(.WIDTH(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .op_sub       (op_sub),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_m         (in_m),
        .busy         (busy),
        .done         (done),
        .result       (result),
        .add_start    (add_start),
        .add_subtract (add_subtract),
        .add_in_a     (add_in_a),
        .add_in_b     (add_in_b),
        .add_result   (add_result),
        .add_done     (add_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [W+1:0] act, input logic [W+1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic logic [W-1:0] rand_w();
        logic [W-1:0] v;
        for (int i = 0; i < W/32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    //--------------------------------------------------------------------------
    // Datapath model: result appears 'cur_lat' cycles after the add_start
    // cycle. In sticky mode add_done (with the old result) stays high between
    // ops and only drops two cycles after add_start.
    //--------------------------------------------------------------------------
    int         cur_lat = 4;
    bit         stale   = 1'b0;
    int         dp_cnt;
    logic [W+1:0] dp_val;

    initial begin
        add_done   = 1'b0;
        add_result = '0;
        dp_cnt     = 0;
        forever begin
            @(posedge clk); #1;
            if (add_start) begin
                dp_val = add_subtract ? ({1'b0, add_in_a} - {1'b0, add_in_b})
                                      : ({1'b0, add_in_a} + {1'b0, add_in_b});
                dp_cnt = cur_lat;
                if (!stale) begin
                    add_done   = 1'b0;
                    add_result = {2'($urandom), rand_w()};
                end
            end else if (dp_cnt > 0) begin
                dp_cnt--;
                if (dp_cnt == 0) begin
                    add_done   = 1'b1;
                    add_result = dp_val;
                end else if (!stale || dp_cnt < cur_lat - 1) begin
                    add_done = 1'b0;
                    if (!stale) add_result = {2'($urandom), rand_w()};
                end
            end else if (!stale) begin
                add_done   = 1'b0;
                add_result = {2'($urandom), rand_w()};
            end
        end
    end

    //--------------------------------------------------------------------------
    // Reference model and per-cycle compare (cycle k = between edges k, k+1).
    // A start seen in an idle cycle 'acc' gives: add_start in acc+1 and
    // acc+L+2, busy in acc+1..acc+2L+3, done in acc+2L+4.
    //--------------------------------------------------------------------------
    bit           m_active = 1'b0;
    int           m_acc, m_dn, m_lat;
    logic         m_op;
    logic [W-1:0] m_a, m_b, m_m, m_exp;
    logic [W-1:0] m_res = '0;
    logic [W:0]   m_raw;

    always @(negedge clk) begin
        bit           ok_acc;
        logic [W+1:0] xa, xb, xm, xe;
        int           j;
        if (reset) begin
            m_active = 1'b0;
            m_res    = '0;
            chk("rst_busy",   busy,         0);
            chk("rst_done",   done,         0);
            chk("rst_astart", add_start,    0);
            chk("rst_asub",   add_subtract, 0);
            chk("rst_ina",    add_in_a,     0);
            chk("rst_inb",    add_in_b,     0);
            chk("rst_result", result,       0);
        end else begin
            j = cyc;
            if (m_active && j == m_dn) m_res = m_exp;
            chk("busy",      busy,      (m_active && j > m_acc && j < m_dn) ? 1 : 0);
            chk("done",      done,      (m_active && j == m_dn) ? 1 : 0);
            chk("add_start", add_start,
                (m_active && (j == m_acc + 1 || j == m_acc + m_lat + 2)) ? 1 : 0);
            chk("result",    result,    m_res);
            if (m_active && j >= m_acc + 1 && j <= m_acc + m_lat + 1) begin
                chk("op1_in_a", add_in_a,     {1'b0, m_a});
                chk("op1_in_b", add_in_b,     {1'b0, m_b});
                chk("op1_mode", add_subtract, m_op);
            end
            if (m_active && j >= m_acc + m_lat + 2 && j <= m_acc + 2*m_lat + 2) begin
                chk("op2_in_a", add_in_a,     m_raw);
                chk("op2_in_b", add_in_b,     {1'b0, m_m});
                chk("op2_mode", add_subtract, !m_op);
            end
            ok_acc = !m_active;
            if (m_active && j == m_dn) m_active = 1'b0;
            if (ok_acc && start) begin
                m_active = 1'b1;
                m_acc = j;
                m_lat = cur_lat;
                m_dn  = j + 2*cur_lat + 4;
                m_op  = op_sub;
                m_a   = in_a;
                m_b   = in_b;
                m_m   = in_m;
                m_raw = op_sub ? ({1'b0, in_a} - {1'b0, in_b}) : ({1'b0, in_a} + {1'b0, in_b});
                xa = {2'b0, in_a};
                xb = {2'b0, in_b};
                xm = {2'b0, in_m};
                if (op_sub) xe = (xa >= xb) ? (xa - xb) : (xa + xm - xb);
                else        xe = (xa + xb) % xm;
                m_exp = xe[W-1:0];
            end
        end
    end

    //--------------------------------------------------------------------------
    // Stimulus helpers
    //--------------------------------------------------------------------------
    task automatic do_op(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] m, input bit lit_en,
                         input logic [W-1:0] lit, input string nm);
        int s_cyc;
        int n;
        @(posedge clk); #1;
        start = 1'b1; op_sub = op; in_a = a; in_b = b; in_m = m;
        s_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0; op_sub = 1'($urandom); in_a = rand_w(); in_b = rand_w(); in_m = rand_w();
        n = 0;
        while (!done && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        if (!done) begin
            chk({nm, "_timeout"}, 0, 1);
        end else begin
            // Latency counts the start-sample cycle and the done cycle.
            chk({nm, "_latency"}, cyc - s_cyc + 1, 2*cur_lat + 5);
            if (lit_en) chk({nm, "_value"}, result, lit);
        end
    endtask

    logic [W-1:0] big_m;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] a, b, m;
        logic         op;
        int           s_cyc;
        reset = 1'b1; start = 1'b0; op_sub = 1'b0;
        in_a = '0; in_b = '0; in_m = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("reset_busy",   busy,   0);
        chk("reset_result", result, 0);

        // Directed small vectors under two datapath latencies.
        for (int k = 0; k < 2; k++) begin
            cur_lat = (k == 0) ? 4 : 17;
            do_op(1'b0, 7, 9, 13, 1, 3, "add_7_9");
            do_op(1'b0, 3, 4, 13, 1, 7, "add_3_4");
            do_op(1'b0, 6, 7, 13, 1, 0, "add_eqm");
            do_op(1'b1, 3, 9, 13, 1, 7, "sub_3_9");
            do_op(1'b1, 9, 3, 13, 1, 6, "sub_9_3");
            do_op(1'b1, 5, 5, 13, 1, 0, "sub_eq");
            big_m = '0;
            big_m[W-1] = 1'b1;
            big_m = big_m + 'h1f;
            do_op(1'b0, big_m - 1, big_m - 1, big_m, 1, big_m - 2, "add_big");
        end

        // Sticky add_done between operations.
        stale = 1'b1;
        for (int k = 0; k < 2; k++) begin
            cur_lat = (k == 0) ? 2 : 5;
            do_op(1'b0, 7, 9, 13, 1, 3, "st_add");
            do_op(1'b1, 3, 9, 13, 1, 7, "st_sub");
            do_op(1'b0, 3, 4, 13, 1, 7, "st_add2");
        end
        stale = 1'b0;

        // start during WAIT1 with different operands is ignored.
        cur_lat = 6;
        @(posedge clk); #1;
        start = 1'b1; op_sub = 1'b1; in_a = 9; in_b = 3; in_m = 13;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1; op_sub = 1'b0; in_a = 7; in_b = 9; in_m = 13;
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 0; n < 100 && !done; n++) begin
            @(posedge clk); #1;
        end
        chk("busy_start_value", result, 6);

        // Reset asserted during WAIT2, then a clean operation.
        cur_lat = 17;
        @(posedge clk); #1;
        start = 1'b1; op_sub = 1'b0; in_a = 7; in_b = 9; in_m = 13;
        s_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        while (cyc < s_cyc + 21) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("midrst_busy",   busy,   0);
        chk("midrst_result", result, 0);
        do_op(1'b0, 7, 9, 13, 1, 3, "after_rst");

        // Randomized operations.
        for (int i = 0; i < 24; i++) begin
            cur_lat = $urandom_range(2, 9);
            stale   = 1'($urandom);
            op      = 1'($urandom);
            if (i % 3 == 0) m = W'($urandom_range(1, 1000));
            else            m = rand_w() | 1;
            a = rand_w() % m;
            b = rand_w() % m;
            if (i % 5 == 1) b = m - 1 - a;
            if (i % 7 == 2) b = a;
            do_op(op, a, b, m, 0, 0, "rnd");
        end
        stale = 1'b0;
        repeat (4) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
